// File: rtl/sdpram_arbiter_pkg.sv
// Shared types and helpers for the sdpram arbiter: port index type and
// a slice extractor for the flattened per-port request buses.
package sdpram_arbiter_pkg;

   localparam int unsigned MaxPorts    = 8;
   localparam int unsigned MaxBusWidth = 64;
   localparam int unsigned MaxVecBits  = MaxPorts * MaxBusWidth;

   typedef logic [$clog2(MaxPorts)-1:0] port_idx_t;

   // Callers zero-extend the flat bus to MaxVecBits and truncate the result.
   function automatic logic [MaxBusWidth-1:0] getSlice(
      input logic [MaxVecBits-1:0] vec,
      input port_idx_t             idx,
      input int unsigned           width
   );
      logic [MaxVecBits-1:0] shifted;
      shifted = vec >> (32'(idx) * width);
      return shifted[MaxBusWidth-1:0];
   endfunction

endpackage

// File: rtl/sdpram_arbiter_if.sv
// Requester-side bundle: per-port request/response handshakes, flattened
// so that port i occupies slice i of each wide vector.
interface sdpram_arbiter_if #(
   parameter int NumPorts     = 2,
   parameter int AddrBusWidth = 32,
   parameter int DataBusWidth = 32
);

   logic [NumPorts-1:0]              req_valid;
   logic [NumPorts-1:0]              req_we;
   logic [NumPorts*AddrBusWidth-1:0] req_addr;
   logic [NumPorts*DataBusWidth-1:0] req_wdata;
   logic [NumPorts-1:0]              req_ready;
   logic [NumPorts-1:0]              rsp_valid;
   logic [NumPorts*DataBusWidth-1:0] rsp_data;
   logic [NumPorts-1:0]              rsp_ready;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_data
   );

endinterface

// File: rtl/sdpram_arbiter_rr_arbiter.sv
// Round-robin arbiter: the search starts at the stored pointer, which moves
// just past the winner whenever the caller reports the grant as taken.
module sdpram_arbiter_rr_arbiter
   import sdpram_arbiter_pkg::*;
#(
   parameter int N = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] grant,
   output port_idx_t    grant_idx,
   output logic         any
);

   port_idx_t    r_ptr;
   logic [N-1:0] w_rot;
   int           w_sum;

   // Rotating the request vector by the pointer turns the search into a
   // plain lowest-set-bit scan.
   always_comb begin
      w_rot = N'({req, req} >> r_ptr);
      any   = 1'b0;
      w_sum = 0;
      for (int k = 0; k < N; k++) begin
         if (!any && w_rot[k]) begin
            any   = 1'b1;
            w_sum = int'(r_ptr) + k;
         end
      end
      grant_idx = port_idx_t'((w_sum >= N) ? (w_sum - N) : w_sum);
      grant     = any ? (N'(1) << grant_idx) : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (advance && any) begin
         r_ptr <= port_idx_t'((int'(grant_idx) + 1) % N);
      end
   end

endmodule

// File: rtl/sdpram_arbiter.sv
// Shares one simple dual-port RAM among NumPorts requesters: writes go to
// port A, reads to port B, each with its own round-robin arbiter.
module sdpram_arbiter
   import sdpram_arbiter_pkg::*;
#(
   parameter int NumPorts     = 2,
   parameter int AddrBusWidth = 32,
   parameter int DataBusWidth = 32,
   parameter int HazardStall  = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   sdpram_arbiter_if.slave         bus,
   output logic [AddrBusWidth-1:0] mem_addr_a,
   output logic                    mem_we_a,
   output logic [DataBusWidth-1:0] mem_w_data_a,
   output logic                    mem_re_b,
   output logic [AddrBusWidth-1:0] mem_addr_b,
   input  logic [DataBusWidth-1:0] mem_r_data_b
);

   logic [NumPorts-1:0]              r_inflight;
   logic [NumPorts-1:0]              r_rspValid;
   logic [NumPorts*DataBusWidth-1:0] r_rspData;

   logic [NumPorts-1:0]     w_slotFree;
   logic [NumPorts-1:0]     w_wrReq;
   logic [NumPorts-1:0]     w_rdReq;
   logic [NumPorts-1:0]     w_wrGrant;
   logic [NumPorts-1:0]     w_rdGrant;
   port_idx_t               w_wrIdx;
   port_idx_t               w_rdIdx;
   logic                    w_wrAny;
   logic                    w_rdAny;
   logic                    w_hazard;
   logic                    w_wrGo;
   logic                    w_rdGo;
   logic [AddrBusWidth-1:0] w_rdAddr;

   // A port may issue a new read in the same cycle its held response drains.
   assign w_slotFree = ~r_inflight & (~r_rspValid | bus.rsp_ready);
   assign w_wrReq    = bus.req_valid & bus.req_we;
   assign w_rdReq    = bus.req_valid & ~bus.req_we & w_slotFree;

   sdpram_arbiter_rr_arbiter #(.N(NumPorts)) u_wrArb (
      .clk       (clk),
      .rst       (rst),
      .req       (w_wrReq),
      .advance   (1'b1),
      .grant     (w_wrGrant),
      .grant_idx (w_wrIdx),
      .any       (w_wrAny)
   );

   sdpram_arbiter_rr_arbiter #(.N(NumPorts)) u_rdArb (
      .clk       (clk),
      .rst       (rst),
      .req       (w_rdReq),
      .advance   (~w_hazard),
      .grant     (w_rdGrant),
      .grant_idx (w_rdIdx),
      .any       (w_rdAny)
   );

   assign mem_addr_a   = AddrBusWidth'(getSlice(MaxVecBits'(bus.req_addr), w_wrIdx, AddrBusWidth));
   assign mem_w_data_a = DataBusWidth'(getSlice(MaxVecBits'(bus.req_wdata), w_wrIdx, DataBusWidth));
   assign w_rdAddr     = AddrBusWidth'(getSlice(MaxVecBits'(bus.req_addr), w_rdIdx, AddrBusWidth));
   assign mem_addr_b   = w_rdAddr;

   // Deferring a same-address read by one cycle makes it return the new data
   // regardless of the RAM's collision behaviour.
   assign w_hazard = (HazardStall != 0) && w_wrAny && w_rdAny && (mem_addr_a == w_rdAddr);
   assign w_wrGo   = w_wrAny & ~rst;
   assign w_rdGo   = w_rdAny & ~w_hazard & ~rst;

   assign mem_we_a      = w_wrGo;
   assign mem_re_b      = w_rdGo;
   assign bus.req_ready = (w_wrGrant & {NumPorts{w_wrGo}}) | (w_rdGrant & {NumPorts{w_rdGo}});
   assign bus.rsp_valid = r_rspValid;
   assign bus.rsp_data  = r_rspData;

   // RAM read latency is one cycle, so a port stays in flight exactly one
   // cycle and its response register loads from the RAM output the next.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_inflight <= '0;
         r_rspValid <= '0;
         r_rspData  <= '0;
      end else begin
         r_inflight <= w_rdGrant & {NumPorts{w_rdGo}};
         for (int i = 0; i < NumPorts; i++) begin
            if (r_inflight[i]) begin
               r_rspValid[i]                             <= 1'b1;
               r_rspData[i*DataBusWidth +: DataBusWidth] <= mem_r_data_b;
            end else if (bus.rsp_ready[i]) begin
               r_rspValid[i] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_sdpram_arbiter.sv
// Directed bench for sdpram_arbiter with a behavioural RAM and per-port
// response scoreboards; a second instance covers HazardStall=0.
module tb_sdpram_arbiter;

   localparam int NP = 2;
   localparam int AW = 32;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst;

   sdpram_arbiter_if #(.NumPorts(NP), .AddrBusWidth(AW), .DataBusWidth(DW)) bus  ();
   sdpram_arbiter_if #(.NumPorts(NP), .AddrBusWidth(AW), .DataBusWidth(DW)) bus2 ();

   logic [AW-1:0] memAddrA, memAddrB, mem2AddrA, mem2AddrB;
   logic          memWeA, memReB, mem2WeA, mem2ReB;
   logic [DW-1:0] memWDataA, memRDataB, mem2WDataA;

   logic [31:0] ram [256] = '{default: '0};
   logic [31:0] shadow [256];
   logic [31:0] expQ0[$];
   logic [31:0] expQ1[$];
   int checks = 0;
   int errors = 0;

   sdpram_arbiter #(.NumPorts(NP), .AddrBusWidth(AW), .DataBusWidth(DW), .HazardStall(1)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus.slave),
      .mem_addr_a   (memAddrA),
      .mem_we_a     (memWeA),
      .mem_w_data_a (memWDataA),
      .mem_re_b     (memReB),
      .mem_addr_b   (memAddrB),
      .mem_r_data_b (memRDataB)
   );

   sdpram_arbiter #(.NumPorts(NP), .AddrBusWidth(AW), .DataBusWidth(DW), .HazardStall(0)) dut2 (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus2.slave),
      .mem_addr_a   (mem2AddrA),
      .mem_we_a     (mem2WeA),
      .mem_w_data_a (mem2WDataA),
      .mem_re_b     (mem2ReB),
      .mem_addr_b   (mem2AddrB),
      .mem_r_data_b (32'h0)
   );

   always #5 clk = ~clk;

   // Behavioural RAM: write at the clock edge, registered read-first port B.
   always @(posedge clk) begin
      if (memWeA) ram[memAddrA[7:0]] <= memWDataA;
      if (memReB) memRDataB <= ram[memAddrB[7:0]];
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Presents one request; reads optionally queue their expected data.
   task automatic applyStimulus(input int port, input logic we, input logic [31:0] addr,
                                input logic [31:0] data, input bit push);
      bus.req_valid[port]           = 1'b1;
      bus.req_we[port]              = we;
      bus.req_addr[port*AW +: AW]   = addr;
      bus.req_wdata[port*DW +: DW]  = data;
      if (we) begin
         shadow[addr[7:0]] = data;
      end else if (push) begin
         if (port == 0) expQ0.push_back(shadow[addr[7:0]]);
         else           expQ1.push_back(shadow[addr[7:0]]);
      end
   endtask

   task automatic waitAccept(input int port, input string tag, input logic we,
                             input logic [31:0] addr, input logic [31:0] data);
      bit seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         if (bus.req_ready[port]) begin
            seen = 1'b1;
            if (we) begin
               checkOutput({tag, "_we_a"}, memWeA, 1'b1);
               checkOutput({tag, "_addr_a"}, memAddrA, addr);
               checkOutput({tag, "_wdata_a"}, memWDataA, data);
            end else begin
               checkOutput({tag, "_re_b"}, memReB, 1'b1);
               checkOutput({tag, "_addr_b"}, memAddrB, addr);
            end
         end
      end
      checkOutput({tag, "_accepted"}, seen, 1'b1);
      @(posedge clk); #1;
      bus.req_valid[port] = 1'b0;
   endtask

   // Scoreboard: every response handshake pops that port's queue.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.rsp_valid[0] && bus.rsp_ready[0]) begin
            checkOutput("rsp0_pending", expQ0.size() != 0, 1'b1);
            if (expQ0.size() != 0) checkOutput("rsp0_data", bus.rsp_data[31:0], expQ0.pop_front());
         end
         if (bus.rsp_valid[1] && bus.rsp_ready[1]) begin
            checkOutput("rsp1_pending", expQ1.size() != 0, 1'b1);
            if (expQ1.size() != 0) checkOutput("rsp1_data", bus.rsp_data[63:32], expQ1.pop_front());
         end
      end
   end

   initial begin
      #50000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int i = 0; i < 256; i++) shadow[i] = '0;
      rst            = 1'b1;
      bus.req_valid  = 2'b11;
      bus.req_we     = 2'b01;
      bus.req_addr   = {32'h10, 32'h10};
      bus.req_wdata  = {32'h0, 32'hA5A5A5A5};
      bus.rsp_ready  = 2'b00;
      bus2.req_valid = '0;
      bus2.req_we    = '0;
      bus2.req_addr  = '0;
      bus2.req_wdata = '0;
      bus2.rsp_ready = 2'b11;

      // Reset with every port requesting.
      repeat (3) begin
         @(negedge clk);
         checkOutput("rst_req_ready", bus.req_ready, 2'b00);
         checkOutput("rst_mem_we_a", memWeA, 1'b0);
         checkOutput("rst_mem_re_b", memReB, 1'b0);
         checkOutput("rst_rsp_valid", bus.rsp_valid, 2'b00);
      end
      checkOutput("rst_rsp_data", bus.rsp_data, 64'h0);
      bus.req_valid = '0;
      @(posedge clk); #1;
      rst           = 1'b0;
      bus.rsp_ready = 2'b11;

      // Write then read back with two-cycle response latency.
      applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
      waitAccept(0, "wr_10", 1'b1, 32'h10, 32'hDEADBEEF);
      applyStimulus(1, 1'b0, 32'h10, 32'h0, 1'b1);
      waitAccept(1, "rd_10", 1'b0, 32'h10, 32'h0);
      @(negedge clk);
      checkOutput("rd_lat_t1", bus.rsp_valid[1], 1'b0);
      @(negedge clk);
      checkOutput("rd_lat_t2", bus.rsp_valid[1], 1'b1);
      checkOutput("rd_lat_data", bus.rsp_data[63:32], 32'hDEADBEEF);

      // Round robin between two continuous readers.
      @(posedge clk); #1;
      applyStimulus(0, 1'b0, 32'h10, 32'h0, 1'b1);
      applyStimulus(1, 1'b0, 32'h40, 32'h0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checkOutput("rr_grant", bus.req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
         checkOutput("rr_re_b", memReB, 1'b1);
         @(posedge clk); #1;
         if (i >= 4) bus.req_valid[i % 2] = 1'b0;
         else applyStimulus(i % 2, 1'b0, (i % 2 == 0) ? 32'h10 : 32'h40, 32'h0, 1'b1);
      end
      repeat (4) @(negedge clk);
      checkOutput("rr_drained", expQ0.size() + expQ1.size(), 0);

      // Same-address write and read in one cycle.
      @(posedge clk); #1;
      applyStimulus(0, 1'b1, 32'h20, 32'h11, 1'b0);
      waitAccept(0, "wr_20_old", 1'b1, 32'h20, 32'h11);
      applyStimulus(0, 1'b1, 32'h20, 32'h55, 1'b0);
      applyStimulus(1, 1'b0, 32'h20, 32'h0, 1'b1);
      bus2.req_valid = 2'b11;
      bus2.req_we    = 2'b01;
      bus2.req_addr  = {32'h20, 32'h20};
      bus2.req_wdata = {32'h0, 32'h55};
      @(negedge clk);
      checkOutput("hz_ready", bus.req_ready, 2'b01);
      checkOutput("hz_we_a", memWeA, 1'b1);
      checkOutput("hz_re_b", memReB, 1'b0);
      checkOutput("nohz_ready", bus2.req_ready, 2'b11);
      checkOutput("nohz_we_a", mem2WeA, 1'b1);
      checkOutput("nohz_re_b", mem2ReB, 1'b1);
      checkOutput("nohz_addr_a", mem2AddrA, 32'h20);
      checkOutput("nohz_wdata_a", mem2WDataA, 32'h55);
      checkOutput("nohz_addr_b", mem2AddrB, 32'h20);
      @(posedge clk); #1;
      bus.req_valid[0] = 1'b0;
      bus2.req_valid   = '0;
      @(negedge clk);
      checkOutput("hz_rd_ready", bus.req_ready, 2'b10);
      checkOutput("hz_rd_addr_b", memAddrB, 32'h20);
      @(posedge clk); #1;
      bus.req_valid[1] = 1'b0;
      @(negedge clk);
      checkOutput("nohz_rsp_valid", bus2.rsp_valid, 2'b10);
      checkOutput("nohz_rsp_data", bus2.rsp_data[63:32], 32'h0);
      repeat (3) @(negedge clk);
      checkOutput("hz_drained", expQ0.size() + expQ1.size(), 0);

      // Backpressure on port 0 while port 1 keeps reading.
      @(posedge clk); #1;
      bus.rsp_ready[0] = 1'b0;
      applyStimulus(0, 1'b0, 32'h10, 32'h0, 1'b1);
      waitAccept(0, "bp_rd0", 1'b0, 32'h10, 32'h0);
      applyStimulus(0, 1'b0, 32'h20, 32'h0, 1'b1);
      applyStimulus(1, 1'b0, 32'h10, 32'h0, 1'b1);
      @(negedge clk);
      checkOutput("bp_p1_ready", bus.req_ready, 2'b10);
      @(posedge clk); #1;
      bus.req_valid[1] = 1'b0;
      repeat (3) begin
         @(negedge clk);
         checkOutput("bp_hold_ready", bus.req_ready, 2'b00);
         checkOutput("bp_hold_valid", bus.rsp_valid[0], 1'b1);
         checkOutput("bp_hold_data", bus.rsp_data[31:0], 32'hDEADBEEF);
         @(posedge clk); #1;
      end
      bus.rsp_ready[0] = 1'b1;
      @(negedge clk);
      checkOutput("bp_regrant", bus.req_ready, 2'b01);
      @(posedge clk); #1;
      bus.req_valid[0] = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("bp_drained", expQ0.size() + expQ1.size(), 0);

      // Reset in the cycle after a read grant drops the read.
      @(posedge clk); #1;
      applyStimulus(1, 1'b0, 32'h10, 32'h0, 1'b0);
      waitAccept(1, "mr_rd", 1'b0, 32'h10, 32'h0);
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         checkOutput("mr_no_rsp", bus.rsp_valid, 2'b00);
      end
      @(posedge clk); #1;
      applyStimulus(1, 1'b0, 32'h10, 32'h0, 1'b1);
      @(negedge clk);
      checkOutput("mr_free_ready", bus.req_ready, 2'b10);
      @(posedge clk); #1;
      bus.req_valid[1] = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("final_drained", expQ0.size() + expQ1.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sdpram_arbiter.md
# sdpram_arbiter

Shares one `sdpram` instance among `NumPorts` requesters. Each requester issues single-word read or write requests over a valid/ready handshake. Writes go to RAM port A and reads to port B, each through its own round-robin arbiter, so one write and one read can be granted in the same cycle. Read data is captured and returned to the owning requester through a one-entry response register with backpressure. It sits between the core-side memory clients and the RAM.

## Interface
- `NumPorts`, 2: number of requesters (2..8).
- `AddrBusWidth`, 32: word address width; matches the RAM.
- `DataBusWidth`, 32: data width; matches the RAM.
- `HazardStall`, 1: 1 = defer a read whose address equals the write granted in the same cycle; 0 = issue both and let the RAM collision mode decide.
- `clk` in 1: the one clock.
- `rst` in 1: **synchronous, active-high** reset.
- `req_valid` in NumPorts: request present, per port.
- `req_we` in NumPorts: 1 = write, 0 = read.
- `req_addr` in NumPorts*AddrBusWidth: word address; port i occupies slice i.
- `req_wdata` in NumPorts*DataBusWidth: write data.
- `req_ready` out NumPorts: request accepted this cycle (combinational).
- `rsp_valid` out NumPorts: read data available (registered).
- `rsp_data` out NumPorts*DataBusWidth: read data (registered).
- `rsp_ready` in NumPorts: requester consumes the response.
- `mem_addr_a`, `mem_we_a`, `mem_w_data_a` out AddrBusWidth/1/DataBusWidth: RAM write port.
- `mem_re_b`, `mem_addr_b` out 1/AddrBusWidth: RAM read port.
- `mem_r_data_b` in DataBusWidth: RAM read data, valid 1 cycle after `mem_re_b`.

## Operation
- **Write arbitration.**
  - Candidates are ports with `req_valid & req_we`.
  - A round-robin pick starts at `wr_ptr`.
  - On a grant: `req_ready[i]=1`, `mem_we_a=1`, and the address and data are muxed from port i.
  - `wr_ptr` becomes (i+1) mod NumPorts.
- **Read arbitration.**
  - Candidates are ports with `req_valid & ~req_we & slot_free[i]`.
  - `slot_free[i] = ~inflight[i] & (~rsp_valid[i] | rsp_ready[i])`.
  - Round-robin pick from `rd_ptr`; on a grant, `mem_re_b=1`, `inflight[i]` is set, and `rd_ptr` becomes (i+1) mod NumPorts.
- **Read return.**
  - The cycle after a grant, `mem_r_data_b` is loaded into `rsp_data[i]`, `rsp_valid[i]` is set, and `inflight[i]` is cleared.
  - `rsp_valid[i]` clears on `rsp_valid[i] & rsp_ready[i]` unless it is reloaded in the same cycle (reload wins).
- **Hazard.** If `HazardStall=1`, a write is granted, and the selected read address equals the write address, no read is granted that cycle and `rd_ptr` holds. The next cycle the read issues and returns the new data.
- **Request rules.**
  - A port presents either a read or a write, never both.
  - Requesters must not make `req_valid` depend on `req_ready`.
  - `req_*` must stay stable until accepted.
- **Combinational and idle outputs.**
  - `mem_*` outputs are combinational from requests and state.
  - When no write is granted, `mem_we_a=0`; `mem_addr_a`/`mem_w_data_a` are don't-care.
  - When no read is granted, `mem_re_b=0`.

## Timing
- **Reset values:**
  - `rsp_valid=0`, `rsp_data=0`, `inflight=0`, `wr_ptr=0`, `rd_ptr=0`.
  - `req_ready=0`, `mem_we_a=0`, `mem_re_b=0` while `rst` is high.
- **Write latency:** accepted in cycle t; written at the t clock edge.
- **Read latency:** accepted in cycle t → RAM data in t+1 → `rsp_valid` in t+2.
- **Throughput:**
  - Per port, one read per 2 cycles when `rsp_ready` is held high.
  - Aggregate, one read plus one write per cycle.
- **Reset mid-operation:** in-flight reads are dropped and no `rsp_valid` rises after reset deasserts. RAM contents are untouched.
- **Fairness:** a continuously requesting port waits at most NumPorts-1 grants. A hazard stall delays the read by 1 cycle only.
- **Simultaneous events:** a response drain and a new grant on the same port in the same cycle is legal (slot-free rule above).

## Structure
- **Package `mem_pkg`:**
  - `port_idx_t` (`$clog2(NumPorts)` bits).
  - A helper function for slice extraction by index.
- **Sub-module `rr_arbiter`:**
  - Parameter `N`; inputs `req[N]` and `advance`.
  - Outputs one-hot `grant`, index `grant_idx`, `any`.
  - Holds an internal pointer with synchronous reset.
  - Instantiated twice (read and write).
- **Top-level logic:** per-port response registers, `inflight` flags, the hazard compare, and the muxes.

## Test plan
- **Reset:** hold `rst` 3 cycles with all ports valid. Expect `req_ready=0`, `mem_we_a=0`, `mem_re_b=0`, `rsp_valid=0`.
- **Write then read:** port0 writes addr 0x10 = 0xDEADBEEF, then port1 reads 0x10. Expect `rsp_valid[1]` 2 cycles after the read grant with `rsp_data[1]=0xDEADBEEF`.
- **Round robin:** ports 0 and 1 both read continuously with `rsp_ready=1`. Expect grants to alternate 0,1,0,1 and the `mem_re_b` duty to be 100%.
- **Hazard:** in the same cycle port0 writes 0x20 = 0x55 (old value 0x11) and port1 reads 0x20. Expect the read granted one cycle later and `rsp_data[1]=0x55`. With `HazardStall=0`, both are granted in the same cycle.
- **Backpressure:** port0 reads with `rsp_ready[0]=0`. Expect `rsp_valid` and `rsp_data` to hold, and a second port0 read not granted until a `rsp_ready` pulse. Port1 reads still proceed.
- **Reset mid-read:** assert `rst` in the cycle after a read grant. Expect no `rsp_valid` after deassert and `inflight` clear.
